// File: rtl/seq_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_counter_ctrl
// Description : Programmable-sequence counter. Steps through a writable table
//               of count values, one-shot or looping, under start/stop.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_last_we,
    input  logic [AW-1:0]    cfg_last,
    input  logic             start,
    input  logic             stop,
    input  logic             step_en,
    input  logic             loop_mode,
    output logic [WIDTH-1:0] count,
    output logic [AW-1:0]    idx,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             cfg_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] C_LAST_RST = AW'(10);

    function automatic logic [WIDTH-1:0] default_entry(input int i);
        case (i)
            1:       default_entry = WIDTH'(2);
            2:       default_entry = WIDTH'(5);
            3:       default_entry = WIDTH'(3);
            4:       default_entry = WIDTH'(6);
            5:       default_entry = WIDTH'(8);
            6:       default_entry = WIDTH'(4);
            7:       default_entry = WIDTH'(1);
            8:       default_entry = WIDTH'(9);
            9:       default_entry = WIDTH'(13);
            10:      default_entry = WIDTH'(12);
            default: default_entry = '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [WIDTH-1:0] tbl_d [DEPTH];
    logic [AW-1:0]    last_q, last_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    idx_inc;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             cfg_err_q, cfg_err_d;

    always_comb begin
        state_d   = state_q;
        tbl_d     = tbl_q;
        last_d    = last_q;
        idx_d     = idx_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        cfg_err_d = 1'b0;
        idx_inc   = idx_q + AW'(1);

        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    tbl_d[cfg_addr] = cfg_data;
                end
                if (cfg_last_we) begin
                    last_d = cfg_last;
                end
                // Reading tbl_d lets a same-cycle write to entry 0 be seen at start.
                if (start && !stop) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    count_d = tbl_d[0];
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                cfg_err_d = cfg_we | cfg_last_we;
                if (stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (step_en) begin
                    if (idx_q != last_q) begin
                        idx_d   = idx_inc;
                        count_d = tbl_q[idx_inc];
                    end else if (loop_mode) begin
                        idx_d   = '0;
                        count_d = tbl_q[0];
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= default_entry(i);
            end
            last_q    <= C_LAST_RST;
            idx_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tbl_q     <= tbl_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign count   = count_q;
    assign idx     = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign wrap    = wrap_q;
    assign cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_counter_ctrl
// Description : Scoreboard bench for seq_counter_ctrl against a sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_counter_ctrl;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [3:0] cfg_data;
    logic       cfg_last_we;
    logic [3:0] cfg_last;
    logic       start;
    logic       stop;
    logic       step_en;
    logic       loop_mode;
    logic [3:0] count;
    logic [3:0] idx;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       cfg_err;

    seq_counter_ctrl #(.WIDTH(4), .DEPTH(16), .AW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_last_we (cfg_last_we),
        .cfg_last    (cfg_last),
        .start       (start),
        .stop        (stop),
        .step_en     (step_en),
        .loop_mode   (loop_mode),
        .count       (count),
        .idx         (idx),
        .busy        (busy),
        .done        (done),
        .wrap        (wrap),
        .cfg_err     (cfg_err)
    );

    typedef struct packed {
        logic [3:0] count;
        logic [3:0] idx;
        logic       busy;
        logic       done;
        logic       wrap;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: sequence position and table contents.
    int  m_tbl [16];
    int  m_last;
    int  m_pos;
    int  m_cnt;
    bit  m_run;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        int defaults [11] = '{0, 2, 5, 3, 6, 8, 4, 1, 9, 13, 12};
        for (int i = 0; i < 16; i++) m_tbl[i] = (i < 11) ? defaults[i] : 0;
        m_last = 10;
        m_pos  = 0;
        m_cnt  = 0;
        m_run  = 0;
    endtask

    task automatic drive(input bit cw, input int ca, input int cd, input bit clw,
                         input int cl, input bit st, input bit sp, input bit se,
                         input bit lm);
        exp_t e;
        bit   e_done = 0;
        bit   e_wrap = 0;
        bit   e_err  = 0;
        cfg_we      = cw;
        cfg_addr    = 4'(ca);
        cfg_data    = 4'(cd);
        cfg_last_we = clw;
        cfg_last    = 4'(cl);
        start       = st;
        stop        = sp;
        step_en     = se;
        loop_mode   = lm;
        if (!m_run) begin
            if (cw)  m_tbl[ca] = cd;
            if (clw) m_last = cl;
            if (st && !sp) begin
                m_run = 1;
                m_pos = 0;
                m_cnt = m_tbl[0];
            end
        end else begin
            e_err = cw | clw;
            if (sp) begin
                m_run = 0;
            end else if (se) begin
                if (m_pos == m_last && !lm) begin
                    e_done = 1;
                    m_run  = 0;
                end else begin
                    m_pos  = (m_pos + 1) % (m_last + 1);
                    e_wrap = (m_pos == 0);
                    m_cnt  = m_tbl[m_pos];
                end
            end
        end
        e = '{count: 4'(m_cnt), idx: 4'(m_pos), busy: m_run, done: e_done,
              wrap: e_wrap, err: e_err};
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = '{count: count, idx: idx, busy: busy, done: done, wrap: wrap, err: cfg_err};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: actual cnt=%0d idx=%0d busy=%b done=%b wrap=%b err=%b required cnt=%0d idx=%0d busy=%b done=%b wrap=%b err=%b",
                         $time, a.count, a.idx, a.busy, a.done, a.wrap, a.err,
                         e.count, e.idx, e.busy, e.done, e.wrap, e.err);
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (count !== 4'd0 || idx !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
            wrap !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: actual cnt=%0d idx=%0d busy=%b done=%b wrap=%b err=%b required all zero",
                     name, count, idx, busy, done, wrap, cfg_err);
        end
    endtask

    initial begin
        cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_last_we = 0; cfg_last = 0;
        start = 0; stop = 0; step_en = 0; loop_mode = 0;
        reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        #1 check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // One-shot walk of the default table.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (11) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) idle_cycle();

        // Looping walk with wrap; start during RUN ignored.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
        repeat (12) drive(0, 0, 0, 0, 0, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle_cycle();

        // Reprogram table and last, then one-shot through it.
        drive(1, 0, 7, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 2, 15, 1, 3, 0, 0, 0, 0);
        drive(1, 3, 4, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle_cycle();

        // Write entry 0 in the same cycle as start.
        drive(1, 0, 11, 0, 0, 1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        repeat (2) idle_cycle();

        // last = 0: one-shot then loop.
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);

        // Asynchronous reset mid-RUN, then default table restored.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (11) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1));
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
